rvfi_compare: RTL and testbench
===============================

// Module: rvfi_compare
// PURPOSE
// - Downstream of the ISS pipeline shell: compares each core RVFI retirement against the
//   reference-model RVFI returned by the ISS for the same instruction.
// - Core retirements are queued in an in-order FIFO. Reference results arrive >=1 cycle later
//   and are matched against the FIFO head.
// - Reports a per-field mismatch mask, match/mismatch counters and sync faults.
// PARAMETERS
// - XLEN        32  data/address width of the compared fields
// - FIFO_DEPTH  4   core-entry queue depth; power of two, >=2
// - CNT_W       32  width of the match/mismatch counters
// PORTS
// - clk             in   1      clock (same clock as the RVFI monitor)
// - reset           in   1      synchronous, active-high reset
// - core_valid      in   1      core retirement valid (one instruction per cycle)
// - core_order      in   64     core rvfi_order
// - core_insn       in   32     core rvfi_insn
// - core_trap       in   1      core rvfi_trap
// - core_pc_rdata   in   XLEN   PC of the retired instruction
// - core_pc_wdata   in   XLEN   next PC
// - core_rd1_addr   in   5      destination register
// - core_rd1_wdata  in   XLEN   destination write data
// - core_mem_addr   in   XLEN   memory address
// - core_mem_rmask  in   XLEN/8 read byte mask
// - core_mem_wmask  in   XLEN/8 write byte mask
// - core_mem_wdata  in   XLEN   memory write data
// - ref_valid       in   1      reference result valid
// - ref_*           in   --     the same 11 fields as core_*, from the ISS output
// - cmp_valid       out  1      comparison result valid (1-cycle pulse)
// - cmp_mismatch    out  1      at least one field differs (qualified by cmp_valid)
// - cmp_field_mask  out  8      mismatching fields, indexed by the cmp_field_e enum
// - cmp_order       out  64     order of the compared instruction
// - match_cnt       out  CNT_W  saturating count of clean compares
// - mismatch_cnt    out  CNT_W  saturating count of mismatching compares
// - fault           out  1      sticky: FIFO overflow or underflow
// - fault_code      out  2      0 none, 1 overflow, 2 underflow
// - state_o         out  2      current cmp_state_e
// BEHAVIOUR
// - Reset values: all outputs 0; FIFO empty; state IDLE.
// - FSM transitions:
//     IDLE->RUN on the first core_valid.
//     RUN->FAULT on overflow or underflow; FAULT holds until reset.
//     RUN->HALTED on a mismatch (only when the optional feature is compiled in).
// - Push: core_valid in IDLE or RUN writes the core fields to the FIFO tail.
// - Pop/compare: ref_valid in RUN with the FIFO non-empty pops the head and compares it
//   against the ref fields.
// - Latency: cmp_* outputs and the counters update on the clock edge after the pop.
//   Compare latency is one cycle.
// - Field-mask bits:
//     0 ORDER, 1 INSN, 2 TRAP, 3 PC_RDATA, 4 PC_WDATA.
//     5 RD1: addr differs, or (addr!=0 and wdata differs). rd1_addr==0 ignores wdata.
//     6 MEM_ADDR: compared only if either side has a nonzero rmask/wmask.
//     7 MEM_W: wmask differs, or (wmask!=0 and wdata differs).
// - Simultaneous push and pop is legal at any occupancy, including full.
// - Underflow: ref_valid with the FIFO empty, even if core_valid arrives the same cycle.
//   There is no bypass path. Sets fault_code=2.
// - Overflow: core_valid with the FIFO full and no pop that cycle. The entry is dropped.
//   Sets fault_code=1.
// - Faults: the first fault code is latched. In FAULT, pushes and compares stop and
//   cmp_valid stays 0.
// - Counters saturate at all-ones and do not wrap.
// - ref_valid in IDLE is an underflow.
// - Reset mid-operation: FIFO flushed, counters cleared, any pending compare discarded.
// CONFIGURATION
// - Macro RVFI_CMP_HALT_ON_MISMATCH_EN.
// - Defined: the first mismatch moves the FSM to HALTED. That compare still reports.
//   Afterwards cmp_valid=0, the counters freeze and the FIFO stops accepting entries.
//   HALTED is left only by reset.
// - Undefined: HALTED is unreachable; mismatches are counted and comparison continues.
// STRUCTURE
// - Package rvfi_cmp_pkg:
//     cmp_state_e {IDLE, RUN, FAULT, HALTED}
//     cmp_field_e, the 8 mask indices
//     cmp_fault_e {NONE, OVERFLOW, UNDERFLOW}
//     rvfi_cmp_entry_t, a packed struct of the 11 compared fields
// - Sub-module rvfi_cmp_fifo: synchronous FIFO of rvfi_cmp_entry_t with push/pop, full and
//   empty. Push-on-full is allowed when a pop occurs in the same cycle.
// - Top level: FSM, field comparator, counters, fault latch.
// TESTING
// - Matched stream: 3 identical core/ref entries, ref lagging 1 cycle
//   -> 3 cmp_valid pulses, mask 0, match_cnt=3.
// - Corrupt ref_rd1_wdata with rd1_addr=5 -> mask=8'h20, mismatch_cnt=1.
//   The same corruption with rd1_addr=0 -> mask 0.
// - Overflow: 5 core_valid with no ref, FIFO_DEPTH=4 -> fault=1, fault_code=1, state FAULT.
// - Underflow: ref_valid right after reset, with core_valid in the same cycle
//   -> fault_code=2, no cmp_valid.
// - Full FIFO with push+pop in the same cycle -> no fault; order sequence preserved (0..7).
// - With RVFI_CMP_HALT_ON_MISMATCH_EN: mismatch on entry 2 of 4
//   -> state HALTED, mismatch_cnt=1, match_cnt=1, no further cmp_valid.
// - Reset asserted while 2 entries are pending -> all outputs 0, IDLE, next stream compares
//   cleanly.

Source files
------------

// File: rtl/rvfi_cmp_pkg.sv
// Shared types for the RVFI core-vs-reference comparator.
// Used by rvfi_cmp_fifo and rvfi_compare.
package rvfi_cmp_pkg;

   localparam int RVFI_XLEN = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FAULT  = 2'd2,
      HALTED = 2'd3
   } cmp_state_e;

   typedef enum logic [2:0] {
      FLD_ORDER    = 3'd0,
      FLD_INSN     = 3'd1,
      FLD_TRAP     = 3'd2,
      FLD_PC_RDATA = 3'd3,
      FLD_PC_WDATA = 3'd4,
      FLD_RD1      = 3'd5,
      FLD_MEM_ADDR = 3'd6,
      FLD_MEM_W    = 3'd7
   } cmp_field_e;

   typedef enum logic [1:0] {
      FLT_NONE      = 2'd0,
      FLT_OVERFLOW  = 2'd1,
      FLT_UNDERFLOW = 2'd2
   } cmp_fault_e;

   typedef struct packed {
      logic [63:0]              order;
      logic [31:0]              insn;
      logic                     trap;
      logic [RVFI_XLEN-1:0]     pc_rdata;
      logic [RVFI_XLEN-1:0]     pc_wdata;
      logic [4:0]               rd1_addr;
      logic [RVFI_XLEN-1:0]     rd1_wdata;
      logic [RVFI_XLEN-1:0]     mem_addr;
      logic [RVFI_XLEN/8-1:0]   mem_rmask;
      logic [RVFI_XLEN/8-1:0]   mem_wmask;
      logic [RVFI_XLEN-1:0]     mem_wdata;
   } rvfi_cmp_entry_t;

   // x0 writes and inactive memory ports carry don't-care data
   function automatic logic [7:0] cmp_fields(input rvfi_cmp_entry_t c,
                                             input rvfi_cmp_entry_t r);
      logic [7:0] m;
      logic       mem_act;
      m = '0;
      mem_act = |{c.mem_rmask, c.mem_wmask, r.mem_rmask, r.mem_wmask};
      m[FLD_ORDER]    = c.order != r.order;
      m[FLD_INSN]     = c.insn != r.insn;
      m[FLD_TRAP]     = c.trap != r.trap;
      m[FLD_PC_RDATA] = c.pc_rdata != r.pc_rdata;
      m[FLD_PC_WDATA] = c.pc_wdata != r.pc_wdata;
      m[FLD_RD1]      = (c.rd1_addr != r.rd1_addr) ||
                        ((c.rd1_addr != '0) && (c.rd1_wdata != r.rd1_wdata));
      m[FLD_MEM_ADDR] = mem_act && (c.mem_addr != r.mem_addr);
      m[FLD_MEM_W]    = (c.mem_wmask != r.mem_wmask) ||
                        ((c.mem_wmask != '0) && (c.mem_wdata != r.mem_wdata));
      return m;
   endfunction

endpackage

// File: rtl/rvfi_cmp_fifo.sv
// In-order queue of core retirements awaiting their reference result.
// Push on full is legal when a pop happens in the same cycle.
module rvfi_cmp_fifo
   import rvfi_cmp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_push,
   input  logic            i_pop,
   input  rvfi_cmp_entry_t i_data,
   output rvfi_cmp_entry_t o_data,
   output logic            o_full,
   output logic            o_empty
);

   localparam int AW = $clog2(DEPTH);

   rvfi_cmp_entry_t r_mem [DEPTH];
   logic [AW:0]     r_wr;
   logic [AW:0]     r_rd;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rd[AW-1:0]];
   assign o_empty = r_wr == r_rd;
   assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/rvfi_compare.sv
// Compares core RVFI retirements against ISS reference results, in order.
// Optional macro RVFI_CMP_HALT_ON_MISMATCH_EN: stop at the first mismatch.
module rvfi_compare
   import rvfi_cmp_pkg::*;
#(
   parameter int XLEN       = RVFI_XLEN,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_valid,
   input  logic [63:0]       core_order,
   input  logic [31:0]       core_insn,
   input  logic              core_trap,
   input  logic [XLEN-1:0]   core_pc_rdata,
   input  logic [XLEN-1:0]   core_pc_wdata,
   input  logic [4:0]        core_rd1_addr,
   input  logic [XLEN-1:0]   core_rd1_wdata,
   input  logic [XLEN-1:0]   core_mem_addr,
   input  logic [XLEN/8-1:0] core_mem_rmask,
   input  logic [XLEN/8-1:0] core_mem_wmask,
   input  logic [XLEN-1:0]   core_mem_wdata,
   input  logic              ref_valid,
   input  logic [63:0]       ref_order,
   input  logic [31:0]       ref_insn,
   input  logic              ref_trap,
   input  logic [XLEN-1:0]   ref_pc_rdata,
   input  logic [XLEN-1:0]   ref_pc_wdata,
   input  logic [4:0]        ref_rd1_addr,
   input  logic [XLEN-1:0]   ref_rd1_wdata,
   input  logic [XLEN-1:0]   ref_mem_addr,
   input  logic [XLEN/8-1:0] ref_mem_rmask,
   input  logic [XLEN/8-1:0] ref_mem_wmask,
   input  logic [XLEN-1:0]   ref_mem_wdata,
   output logic              cmp_valid,
   output logic              cmp_mismatch,
   output logic [7:0]        cmp_field_mask,
   output logic [63:0]       cmp_order,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [CNT_W-1:0]  mismatch_cnt,
   output logic              fault,
   output logic [1:0]        fault_code,
   output logic [1:0]        state_o
);

   cmp_state_e      r_state, w_state_nxt;
   cmp_fault_e      r_fault_code;
   rvfi_cmp_entry_t w_core, w_ref, w_head;
   logic            w_full, w_empty, w_active;
   logic            w_push, w_pop, w_ovf, w_unf, w_fault_ev;
   logic [7:0]      w_mask;
   logic            w_mis;
   logic            r_cmp_valid, r_cmp_mismatch, r_fault;
   logic [7:0]      r_cmp_mask;
   logic [63:0]     r_cmp_order;
   logic [CNT_W-1:0] r_match_cnt, r_mismatch_cnt;

   assign w_core = '{core_order, core_insn, core_trap, core_pc_rdata,
                     core_pc_wdata, core_rd1_addr, core_rd1_wdata,
                     core_mem_addr, core_mem_rmask, core_mem_wmask,
                     core_mem_wdata};
   assign w_ref  = '{ref_order, ref_insn, ref_trap, ref_pc_rdata,
                     ref_pc_wdata, ref_rd1_addr, ref_rd1_wdata,
                     ref_mem_addr, ref_mem_rmask, ref_mem_wmask,
                     ref_mem_wdata};

   // No bypass: a ref result can only match an entry queued earlier
   assign w_active   = (r_state == IDLE) || (r_state == RUN);
   assign w_pop      = ref_valid && (r_state == RUN) && !w_empty;
   assign w_unf      = ref_valid && w_active && w_empty;
   assign w_ovf      = core_valid && (r_state == RUN) && w_full && !w_pop;
   assign w_fault_ev = w_unf || w_ovf;
   assign w_push     = core_valid && w_active && !w_fault_ev &&
                       (!w_full || w_pop);

   assign w_mask = cmp_fields(w_head, w_ref);
   assign w_mis  = |w_mask;

   rvfi_cmp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_core),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_fault_ev)      w_state_nxt = FAULT;
            else if (core_valid) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_fault_ev) w_state_nxt = FAULT;
`ifdef RVFI_CMP_HALT_ON_MISMATCH_EN
            else if (w_pop && w_mis) w_state_nxt = HALTED;
`endif
         end
         default: w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_fault_code   <= FLT_NONE;
         r_fault        <= 1'b0;
         r_cmp_valid    <= 1'b0;
         r_cmp_mismatch <= 1'b0;
         r_cmp_mask     <= '0;
         r_cmp_order    <= '0;
         r_match_cnt    <= '0;
         r_mismatch_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmp_valid <= w_pop;
         if (w_pop) begin
            r_cmp_mismatch <= w_mis;
            r_cmp_mask     <= w_mask;
            r_cmp_order    <= w_head.order;
            if (w_mis) begin
               if (r_mismatch_cnt != '1)
                  r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            end else if (r_match_cnt != '1) begin
               r_match_cnt <= r_match_cnt + 1'b1;
            end
         end
         if (w_fault_ev && !r_fault) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_ovf ? FLT_OVERFLOW : FLT_UNDERFLOW;
         end
      end
   end

   assign cmp_valid      = r_cmp_valid;
   assign cmp_mismatch   = r_cmp_mismatch;
   assign cmp_field_mask = r_cmp_mask;
   assign cmp_order      = r_cmp_order;
   assign match_cnt      = r_match_cnt;
   assign mismatch_cnt   = r_mismatch_cnt;
   assign fault          = r_fault;
   assign fault_code     = r_fault_code;
   assign state_o        = r_state;

endmodule

// File: tb/tb_rvfi_compare.sv
// Directed bench for rvfi_compare; halt scenario runs only when
// RVFI_CMP_HALT_ON_MISMATCH_EN is defined.
module tb_rvfi_compare;
   import rvfi_cmp_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              core_valid, ref_valid;
   logic [63:0]       core_order, ref_order;
   logic [31:0]       core_insn, ref_insn;
   logic              core_trap, ref_trap;
   logic [XLEN-1:0]   core_pc_rdata, ref_pc_rdata;
   logic [XLEN-1:0]   core_pc_wdata, ref_pc_wdata;
   logic [4:0]        core_rd1_addr, ref_rd1_addr;
   logic [XLEN-1:0]   core_rd1_wdata, ref_rd1_wdata;
   logic [XLEN-1:0]   core_mem_addr, ref_mem_addr;
   logic [XLEN/8-1:0] core_mem_rmask, ref_mem_rmask;
   logic [XLEN/8-1:0] core_mem_wmask, ref_mem_wmask;
   logic [XLEN-1:0]   core_mem_wdata, ref_mem_wdata;
   logic              cmp_valid, cmp_mismatch, fault;
   logic [7:0]        cmp_field_mask;
   logic [63:0]       cmp_order;
   logic [CNT_W-1:0]  match_cnt, mismatch_cnt;
   logic [1:0]        fault_code, state_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rvfi_compare #(.XLEN(XLEN), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .core_valid(core_valid), .core_order(core_order),
      .core_insn(core_insn), .core_trap(core_trap),
      .core_pc_rdata(core_pc_rdata), .core_pc_wdata(core_pc_wdata),
      .core_rd1_addr(core_rd1_addr), .core_rd1_wdata(core_rd1_wdata),
      .core_mem_addr(core_mem_addr), .core_mem_rmask(core_mem_rmask),
      .core_mem_wmask(core_mem_wmask), .core_mem_wdata(core_mem_wdata),
      .ref_valid(ref_valid), .ref_order(ref_order),
      .ref_insn(ref_insn), .ref_trap(ref_trap),
      .ref_pc_rdata(ref_pc_rdata), .ref_pc_wdata(ref_pc_wdata),
      .ref_rd1_addr(ref_rd1_addr), .ref_rd1_wdata(ref_rd1_wdata),
      .ref_mem_addr(ref_mem_addr), .ref_mem_rmask(ref_mem_rmask),
      .ref_mem_wmask(ref_mem_wmask), .ref_mem_wdata(ref_mem_wdata),
      .cmp_valid(cmp_valid), .cmp_mismatch(cmp_mismatch),
      .cmp_field_mask(cmp_field_mask), .cmp_order(cmp_order),
      .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
      .fault(fault), .fault_code(fault_code), .state_o(state_o)
   );

   typedef struct {
      logic [4:0]  rd1;
      logic [3:0]  c_rmask;
      logic [3:0]  c_wmask;
      logic [3:0]  r_wmask;
      logic [63:0] x_order;
      logic [31:0] x_insn;
      logic        x_trap;
      logic [31:0] x_pcr;
      logic [31:0] x_pcw;
      logic [31:0] x_rd1w;
      logic [31:0] x_maddr;
      logic [31:0] x_mwdata;
      logic [7:0]  exp_mask;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic rvfi_cmp_entry_t mk(input int k);
      rvfi_cmp_entry_t e;
      e.order     = 64'(k);
      e.insn      = 32'h0000_0013 | (32'(k) << 20);
      e.trap      = 1'b0;
      e.pc_rdata  = 32'h8000_0000 + 32'(4 * k);
      e.pc_wdata  = 32'h8000_0004 + 32'(4 * k);
      e.rd1_addr  = 5'(k % 31 + 1);
      e.rd1_wdata = 32'hdead_0000 ^ 32'(k);
      e.mem_addr  = 32'h0000_1000 + 32'(4 * k);
      e.mem_rmask = 4'h0;
      e.mem_wmask = 4'h0;
      e.mem_wdata = 32'hcafe_0000 + 32'(k);
      return e;
   endfunction

   task automatic drv_core(input logic v, input rvfi_cmp_entry_t e);
      core_valid     = v;
      core_order     = e.order;
      core_insn      = e.insn;
      core_trap      = e.trap;
      core_pc_rdata  = e.pc_rdata;
      core_pc_wdata  = e.pc_wdata;
      core_rd1_addr  = e.rd1_addr;
      core_rd1_wdata = e.rd1_wdata;
      core_mem_addr  = e.mem_addr;
      core_mem_rmask = e.mem_rmask;
      core_mem_wmask = e.mem_wmask;
      core_mem_wdata = e.mem_wdata;
   endtask

   task automatic drv_ref(input logic v, input rvfi_cmp_entry_t e);
      ref_valid     = v;
      ref_order     = e.order;
      ref_insn      = e.insn;
      ref_trap      = e.trap;
      ref_pc_rdata  = e.pc_rdata;
      ref_pc_wdata  = e.pc_wdata;
      ref_rd1_addr  = e.rd1_addr;
      ref_rd1_wdata = e.rd1_wdata;
      ref_mem_addr  = e.mem_addr;
      ref_mem_rmask = e.mem_rmask;
      ref_mem_wmask = e.mem_wmask;
      ref_mem_wdata = e.mem_wdata;
   endtask

   task automatic do_reset();
      drv_core(1'b0, mk(0));
      drv_ref(1'b0, mk(0));
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   function automatic vec_t mv(input logic [4:0] rd1,
                               input logic [3:0] crm, input logic [3:0] cwm,
                               input logic [3:0] rwm,
                               input logic [63:0] xo, input logic [31:0] xi,
                               input logic xt, input logic [31:0] xpr,
                               input logic [31:0] xpw, input logic [31:0] xrw,
                               input logic [31:0] xma, input logic [31:0] xmw,
                               input logic [7:0] em);
      vec_t v;
      v.rd1 = rd1; v.c_rmask = crm; v.c_wmask = cwm; v.r_wmask = rwm;
      v.x_order = xo; v.x_insn = xi; v.x_trap = xt;
      v.x_pcr = xpr; v.x_pcw = xpw; v.x_rd1w = xrw;
      v.x_maddr = xma; v.x_mwdata = xmw; v.exp_mask = em;
      return v;
   endfunction

   initial begin
      rvfi_cmp_entry_t c, r;
      reset = 1'b1;
      drv_core(1'b0, mk(0));
      drv_ref(1'b0, mk(0));

      //            rd1 crm  cwm  rwm  order insn trap pcr pcw rd1w maddr mwd  mask
      vecs[0]  = mv(5, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      vecs[1]  = mv(5, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h20);
      vecs[2]  = mv(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
      vecs[3]  = mv(5, 4'h0, 4'h0, 4'h0, 0, 4, 0, 0, 0, 0, 0, 0, 8'h02);
      vecs[4]  = mv(5, 4'h0, 4'h0, 4'h0, 8, 0, 0, 0, 0, 0, 0, 0, 8'h01);
      vecs[5]  = mv(5, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h04);
      vecs[6]  = mv(5, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4, 0, 0, 0, 0, 8'h08);
      vecs[7]  = mv(5, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4, 0, 0, 0, 8'h10);
      vecs[8]  = mv(5, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4, 0, 8'h00);
      vecs[9]  = mv(5, 4'hf, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4, 0, 8'h40);
      vecs[10] = mv(5, 4'h0, 4'h0, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0, 8'h80);
      vecs[11] = mv(5, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
      vecs[12] = mv(5, 4'h0, 4'hf, 4'hf, 0, 0, 0, 0, 0, 0, 0, 1, 8'h80);

      do_reset();
      chk("rst_cmp_valid", cmp_valid, 0);
      chk("rst_match_cnt", match_cnt, 0);
      chk("rst_fault", fault, 0);
      chk("rst_fault_code", fault_code, 0);
      chk("rst_state", state_o, 0);
      chk("rst_mask", cmp_field_mask, 0);

      for (int i = 0; i < 13; i++) begin
         do_reset();
         c = mk(i);
         c.rd1_addr  = vecs[i].rd1;
         c.mem_rmask = vecs[i].c_rmask;
         c.mem_wmask = vecs[i].c_wmask;
         r = c;
         r.order     ^= vecs[i].x_order;
         r.insn      ^= vecs[i].x_insn;
         r.trap      ^= vecs[i].x_trap;
         r.pc_rdata  ^= vecs[i].x_pcr;
         r.pc_wdata  ^= vecs[i].x_pcw;
         r.rd1_wdata ^= vecs[i].x_rd1w;
         r.mem_addr  ^= vecs[i].x_maddr;
         r.mem_wdata ^= vecs[i].x_mwdata;
         r.mem_wmask  = vecs[i].r_wmask;
         drv_core(1'b1, c);
         step();
         chk($sformatf("v%0d_early_valid", i), cmp_valid, 0);
         drv_core(1'b0, c);
         drv_ref(1'b1, r);
         step();
         drv_ref(1'b0, r);
         chk($sformatf("v%0d_valid", i), cmp_valid, 1);
         chk($sformatf("v%0d_mask", i), cmp_field_mask, vecs[i].exp_mask);
         chk($sformatf("v%0d_mismatch", i), cmp_mismatch,
             64'(vecs[i].exp_mask != 0));
         chk($sformatf("v%0d_match_cnt", i), match_cnt,
             64'(vecs[i].exp_mask == 0));
         chk($sformatf("v%0d_mismatch_cnt", i), mismatch_cnt,
             64'(vecs[i].exp_mask != 0));
         chk($sformatf("v%0d_order", i), cmp_order, c.order);
         step();
         chk($sformatf("v%0d_pulse", i), cmp_valid, 0);
      end

      // matched stream, ref one cycle behind
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drv_core(k < 3, mk(k));
         drv_ref(k > 0, mk(k - 1));
         step();
         chk($sformatf("ms_valid%0d", k), cmp_valid, 64'(k > 0));
         if (k > 0) chk($sformatf("ms_order%0d", k), cmp_order, 64'(k - 1));
      end
      drv_ref(1'b0, mk(0));
      step();
      chk("ms_match_cnt", match_cnt, 3);
      chk("ms_mismatch_cnt", mismatch_cnt, 0);
      chk("ms_state", state_o, 1);

      // overflow
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drv_core(1'b1, mk(k));
         step();
      end
      drv_core(1'b0, mk(0));
      chk("ovf_fault", fault, 1);
      chk("ovf_code", fault_code, 1);
      chk("ovf_state", state_o, 2);
      drv_ref(1'b1, mk(0));
      step();
      drv_ref(1'b0, mk(0));
      step();
      chk("ovf_no_cmp", cmp_valid, 0);
      chk("ovf_code_held", fault_code, 1);

      // underflow with simultaneous push
      do_reset();
      drv_core(1'b1, mk(0));
      drv_ref(1'b1, mk(0));
      step();
      chk("unf_code", fault_code, 2);
      chk("unf_fault", fault, 1);
      chk("unf_state", state_o, 2);
      chk("unf_no_cmp0", cmp_valid, 0);
      step();
      chk("unf_no_cmp1", cmp_valid, 0);
      chk("unf_code_held", fault_code, 2);
      drv_core(1'b0, mk(0));
      drv_ref(1'b0, mk(0));

      // full FIFO, push+pop together, counter saturates at 7
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drv_core(1'b1, mk(k));
         step();
      end
      for (int k = 0; k < 8; k++) begin
         drv_core(k < 4, mk(k + 4));
         drv_ref(1'b1, mk(k));
         step();
         chk($sformatf("ff_valid%0d", k), cmp_valid, 1);
         chk($sformatf("ff_order%0d", k), cmp_order, 64'(k));
         chk($sformatf("ff_fault%0d", k), fault, 0);
      end
      drv_core(1'b0, mk(0));
      drv_ref(1'b0, mk(0));
      step();
      chk("ff_match_sat", match_cnt, 7);
      chk("ff_mismatch_cnt", mismatch_cnt, 0);
      chk("ff_state", state_o, 1);

`ifdef RVFI_CMP_HALT_ON_MISMATCH_EN
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drv_core(1'b1, mk(k));
         step();
      end
      drv_core(1'b0, mk(0));
      for (int k = 0; k < 4; k++) begin
         r = mk(k);
         if (k == 1) r.insn ^= 32'h1;
         drv_ref(1'b1, r);
         step();
         chk($sformatf("h_valid%0d", k), cmp_valid, 64'(k < 2));
      end
      drv_ref(1'b0, mk(0));
      step();
      chk("h_state", state_o, 3);
      chk("h_match_cnt", match_cnt, 1);
      chk("h_mismatch_cnt", mismatch_cnt, 1);
      chk("h_no_cmp", cmp_valid, 0);
`endif

      // reset with two entries pending
      do_reset();
      drv_core(1'b1, mk(0));
      step();
      drv_core(1'b1, mk(1));
      step();
      drv_core(1'b0, mk(0));
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_state", state_o, 0);
      chk("mr_match_cnt", match_cnt, 0);
      chk("mr_order", cmp_order, 0);
      chk("mr_cmp_valid", cmp_valid, 0);
      drv_core(1'b1, mk(10));
      step();
      drv_core(1'b1, mk(11));
      drv_ref(1'b1, mk(10));
      step();
      chk("mr_order10", cmp_order, 10);
      chk("mr_clean10", cmp_mismatch, 0);
      drv_core(1'b0, mk(0));
      drv_ref(1'b1, mk(11));
      step();
      chk("mr_order11", cmp_order, 11);
      drv_ref(1'b0, mk(0));
      step();
      chk("mr_match_cnt2", match_cnt, 2);
      chk("mr_mismatch_cnt", mismatch_cnt, 0);
      chk("mr_fault", fault, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
